// File: rtl/text_console_writer.sv
// text_console_writer: turns a valid/ready ASCII byte stream into video-memory
// writes. Tracks a text cursor, handles CR/LF/BS/FF and blanks rows or the
// whole screen. All memory-side outputs are registered.
module text_console_writer #(
  parameter int          COLS  = 80,
  parameter int          ROWS  = 30,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        mem_ready,
  input  logic [7:0]  ch_data,
  input  logic        ch_valid,
  output logic        ch_ready,
  output logic [11:0] w_addr,
  output logic [7:0]  w_data,
  output logic        w_valid,
  output logic [5:0]  cur_row,
  output logic [6:0]  cur_col,
  output logic        busy
);

  typedef enum logic [1:0] {WAIT_INIT, IDLE, CLEAR_ROW, CLEAR_ALL} state_e;

  localparam logic [12:0] CELLS    = 13'(COLS * ROWS);
  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
  localparam logic [5:0]  LAST_ROW = 6'(ROWS - 1);

  state_e      state_q, state_d;
  logic [5:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic [11:0] waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        wvld_q, wvld_d;
  logic [11:0] caddr_q, caddr_d;   // next address to blank
  logic [12:0] ccnt_q, ccnt_d;     // blank writes still owed

  logic [5:0]  nl_row;
  logic [11:0] nl_base, cur_addr;
  logic        accept, do_nl;

  assign nl_row   = (row_q == LAST_ROW) ? 6'd0 : row_q + 6'd1;
  assign nl_base  = 12'(nl_row) * 12'(COLS);
  assign cur_addr = 12'(row_q) * 12'(COLS) + 12'(col_q);
  assign ch_ready = (state_q == IDLE);
  assign accept   = ch_valid && ch_ready;

  // Next-state, cursor and write-port decode.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wvld_d  = 1'b0;
    caddr_d = caddr_q;
    ccnt_d  = ccnt_q;
    do_nl   = 1'b0;
    case (state_q)
      WAIT_INIT: if (mem_ready) state_d = IDLE;
      IDLE: begin
        if (accept) begin
          if (ch_data >= 8'h20 && ch_data <= 8'h7E) begin
            waddr_d = cur_addr;
            wdata_d = ch_data;
            wvld_d  = 1'b1;
            if (col_q == LAST_COL) do_nl = 1'b1;
            else                   col_d = col_q + 7'd1;
          end else begin
            case (ch_data)
              8'h0A: do_nl = 1'b1;
              8'h0D: col_d = 7'd0;
              8'h08: if (col_q != 7'd0) begin
                col_d   = col_q - 7'd1;
                waddr_d = cur_addr - 12'd1;
                wdata_d = BLANK;
                wvld_d  = 1'b1;
              end
              8'h0C: begin
                row_d   = 6'd0;
                col_d   = 7'd0;
                caddr_d = 12'd0;
                ccnt_d  = CELLS;
                state_d = CLEAR_ALL;
              end
              default: ;  // unknown control codes are swallowed
            endcase
          end
        end
      end
      CLEAR_ROW, CLEAR_ALL: begin
        if (ccnt_q != 13'd0) begin
          waddr_d = caddr_q;
          wdata_d = BLANK;
          wvld_d  = 1'b1;
          caddr_d = caddr_q + 12'd1;
          ccnt_d  = ccnt_q - 13'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = WAIT_INIT;
    endcase
    if (do_nl) begin
      col_d   = 7'd0;
      row_d   = nl_row;
      caddr_d = nl_base;
      ccnt_d  = 13'(COLS);
      state_d = CLEAR_ROW;
    end
    // Memory re-init wipes the screen itself, so any clear is dropped here.
    if (!mem_ready) begin
      state_d = WAIT_INIT;
      row_d   = 6'd0;
      col_d   = 7'd0;
      wvld_d  = 1'b0;
    end
  end

  // State, cursor and registered write port.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q <= WAIT_INIT;
      row_q   <= 6'd0;
      col_q   <= 7'd0;
      waddr_q <= 12'd0;
      wdata_q <= 8'd0;
      wvld_q  <= 1'b0;
      caddr_q <= 12'd0;
      ccnt_q  <= 13'd0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wvld_q  <= wvld_d;
      caddr_q <= caddr_d;
      ccnt_q  <= ccnt_d;
    end
  end

  assign w_addr  = waddr_q;
  assign w_data  = wdata_q;
  assign w_valid = wvld_q;
  assign cur_row = row_q;
  assign cur_col = col_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_text_console_writer.sv
// Scoreboard bench for text_console_writer: stimulus pushes expected writes,
// a negedge monitor pops and compares every w_valid cycle.
module tb_text_console_writer;
  logic        clk = 1'b0, reset_p = 1'b1, mem_ready = 1'b0, ch_valid = 1'b0;
  logic [7:0]  ch_data = 8'd0;
  logic        ch_ready, w_valid, busy;
  logic [11:0] w_addr;
  logic [7:0]  w_data;
  logic [5:0]  cur_row;
  logic [6:0]  cur_col;

  typedef struct packed { logic [11:0] a; logic [7:0] d; } wr_t;
  wr_t exp_q[$];
  int  checks = 0, errors = 0;
  bit  mon_en = 1'b1;

  text_console_writer #(.COLS(80), .ROWS(30), .BLANK(8'h20)) dut (
    .clk(clk), .reset_p(reset_p), .mem_ready(mem_ready),
    .ch_data(ch_data), .ch_valid(ch_valid), .ch_ready(ch_ready),
    .w_addr(w_addr), .w_data(w_data), .w_valid(w_valid),
    .cur_row(cur_row), .cur_col(cur_col), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the expected queue.
  always @(negedge clk) begin
    wr_t e;
    if (mon_en && w_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: addr %0d data %h, none expected", w_addr, w_data);
      end else begin
        e = exp_q.pop_front();
        chk("w_addr", int'(w_addr), int'(e.a));
        chk("w_data", int'(w_data), int'(e.d));
      end
    end
  end

  task automatic push(input int a, input int d);
    exp_q.push_back('{a: 12'(a), d: 8'(d)});
  endtask

  task automatic push_row(input int r);
    for (int c = 0; c < 80; c++) push(r * 80 + c, 8'h20);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (ch_ready !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    if (ch_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s_timeout: ch_ready=%b after %0d cycles, expected 1", name, ch_ready, n);
    end
  endtask

  // Called at a negedge; leaves ch_valid low at the negedge after acceptance.
  task automatic send(input logic [7:0] b);
    ch_data  = b;
    ch_valid = 1'b1;
    wait_ready("send");
    @(posedge clk);
    @(negedge clk);
    ch_valid = 1'b0;
  endtask

  task automatic settle();
    wait_ready("settle");
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic cursor(input int r, input int c);
    chk("cur_row", int'(cur_row), r);
    chk("cur_col", int'(cur_col), c);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ch_ready", ch_ready, 0);
    chk("rst_w_valid", w_valid, 0);
    chk("rst_busy", busy, 1);
    chk("rst_w_addr", int'(w_addr), 0);
    chk("rst_w_data", int'(w_data), 0);
    cursor(0, 0);
    reset_p = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("wait_ch_ready", ch_ready, 0);
      chk("wait_w_valid", w_valid, 0);
    end
    mem_ready = 1'b1;
    chk("pre_edge_ch_ready", ch_ready, 0);
    @(negedge clk);
    chk("init_ch_ready", ch_ready, 1);
    chk("init_busy", busy, 0);

    // "AB" back-to-back
    push(0, 8'h41); push(1, 8'h42);
    send(8'h41); send(8'h42);
    settle(); cursor(0, 2);

    // Full row then auto-wrap clear of row 1
    send(8'h0D);
    for (int i = 0; i < 80; i++) begin
      push(i, 8'h41 + (i % 26));
      send(8'(8'h41 + (i % 26)));
    end
    push_row(1);
    chk("clr_row_ch_ready", ch_ready, 0);
    repeat (40) @(negedge clk);
    chk("mid_clr_ch_ready", ch_ready, 0);
    chk("mid_clr_busy", busy, 1);
    settle(); cursor(1, 0);
    chk("after_clr_ch_ready", ch_ready, 1);

    // Walk to (29,5), then LF wraps to row 0
    for (int r = 2; r < 30; r++) begin push_row(r); send(8'h0A); end
    for (int i = 0; i < 5; i++) begin push(2320 + i, 8'h78); send(8'h78); end
    settle(); cursor(29, 5);
    push_row(0); send(8'h0A);
    settle(); cursor(0, 0);

    // (3,4): BS, CR, BS at column 0
    for (int r = 1; r < 4; r++) begin push_row(r); send(8'h0A); end
    for (int i = 0; i < 4; i++) begin push(240 + i, 8'h61 + i); send(8'(8'h61 + i)); end
    push(243, 8'h20); send(8'h08);
    settle(); cursor(3, 3);
    send(8'h0D); settle(); cursor(3, 0);
    send(8'h08); settle(); cursor(3, 0);

    // (7,10): FF clears whole screen
    for (int r = 4; r < 8; r++) begin push_row(r); send(8'h0A); end
    for (int i = 0; i < 10; i++) begin push(560 + i, 8'h30 + i); send(8'(8'h30 + i)); end
    settle(); cursor(7, 10);
    for (int a = 0; a < 2400; a++) push(a, 8'h20);
    send(8'h0C);
    settle(); cursor(0, 0);
    send(8'h07); settle(); cursor(0, 0);

    // Reset during CLEAR_ALL
    mon_en = 1'b0;
    send(8'h0C);
    repeat (20) @(negedge clk);
    reset_p = 1'b1;
    #1;
    chk("rst_abort_w_valid", w_valid, 0);
    chk("rst_abort_ch_ready", ch_ready, 0);
    chk("rst_abort_busy", busy, 1);
    cursor(0, 0);
    @(negedge clk);
    reset_p = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    settle(); cursor(0, 0);

    // mem_ready drop during CLEAR_ROW with a held byte
    mon_en = 1'b0;
    send(8'h0A);
    repeat (10) @(negedge clk);
    mem_ready = 1'b0;
    ch_data   = 8'h5A;
    ch_valid  = 1'b1;
    @(negedge clk);
    chk("drop_w_valid", w_valid, 0);
    chk("drop_ch_ready", ch_ready, 0);
    chk("drop_busy", busy, 1);
    cursor(0, 0);
    repeat (5) @(negedge clk);
    chk("drop_hold_ch_ready", ch_ready, 0);
    exp_q.delete();
    mon_en = 1'b1;
    push(0, 8'h5A);
    mem_ready = 1'b1;
    wait_ready("held_byte");
    @(posedge clk);
    @(negedge clk);
    ch_valid = 1'b0;
    settle(); cursor(0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
